// File: rtl/result_unload.sv
// Burst reader: streams a contiguous register-file range out through a small
// FIFO with valid/ready handshake, issuing reads only when buffer space is reserved.
module result_unload #(
  parameter int DATA_WIDTH    = 32,
  parameter int RAM_ADDR_BITS = 5,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [RAM_ADDR_BITS:0]   length,
  output logic [RAM_ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int LEN_W = RAM_ADDR_BITS + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** RAM_ADDR_BITS);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] remaining;   // reads still to issue
  logic [LEN_W-1:0] out_left;    // words still to hand to the consumer
  logic             v_addr;      // rd_addr holds an issued read this cycle
  logic             v_data;      // rd_data holds returned data this cycle
  logic             zero_done;
  logic             issue;
  logic             push;
  logic             pop;
  logic             credit_ok;
  logic [SUM_W-1:0] reserved;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign eff_len    = (length > MAX_LEN) ? MAX_LEN : length;
  assign dout_valid = (count != '0);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;
  assign push       = v_data;
  assign pop        = dout_valid && dout_ready;
  assign busy       = (state != IDLE);

  // Words already buffered plus reads still in the two-stage return pipe.
  assign reserved  = {1'b0, count} + SUM_W'(v_addr) + SUM_W'(v_data);
  assign credit_ok = (reserved < SUM_W'(FIFO_DEPTH));

  assign done = !rst && (zero_done ||
                (pop && state != IDLE && out_left == LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && eff_len != '0) begin
          issue      = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if (remaining == '0) begin
          state_next = DRAIN;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (remaining == LEN_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_left == LEN_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      remaining <= '0;
      out_left  <= '0;
      v_addr    <= 1'b0;
      v_data    <= 1'b0;
      zero_done <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      zero_done <= (state == IDLE) && start && (eff_len == '0);
      v_addr    <= issue;
      v_data    <= v_addr;

      if (issue) begin
        if (state == IDLE) begin
          rd_addr   <= base_addr;
          remaining <= eff_len - LEN_W'(1);
          out_left  <= eff_len;
        end else begin
          rd_addr   <= rd_addr + RAM_ADDR_BITS'(1);
          remaining <= remaining - LEN_W'(1);
        end
      end

      if (pop && state != IDLE) out_left <= out_left - LEN_W'(1);

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the storage array has no reset; dout is masked while the FIFO is empty,
  // so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_result_unload.sv
// Directed bench for result_unload with a synchronous-read register-file model
// holding RAM[i] = i + 100.
module tb_result_unload;

  localparam int DW = 32;
  localparam int AB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AB-1:0] base_addr;
  logic [AB:0]   length;
  logic [AB-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [32];

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= ram[rd_addr];

  result_unload #(.DATA_WIDTH(DW), .RAM_ADDR_BITS(AB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .rd_addr(rd_addr), .rd_data(rd_data), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  // Pulses start for one cycle; returns at the falling edge of cycle 1.
  task automatic issue_start(input logic [AB-1:0] b, input logic [AB:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout_valid, busy, done} !== 3'b000 || rd_addr !== '0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b rd_addr=%0d dout=%0d, want 0s",
               dout_valid, busy, done, rd_addr, dout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    dout_ready = 1'b1;
    issue_start(5'd3, 6'd4);
    checks++;
    if (rd_addr !== 5'd3 || busy !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_cycle1: rd_addr=%0d busy=%b valid=%b, want 3 1 0",
               rd_addr, busy, dout_valid);
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_cycle2_valid: got %b want 0", dout_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b1 || dout !== DW'(103 + k) || done !== (k == 3)) begin
        errors++;
        $display("FAIL basic_word%0d: valid=%b dout=%0d done=%b, want 1 %0d %b",
                 k, dout_valid, dout, done, 103 + k, k == 3);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: busy=%b done=%b valid=%b, want 0 0 0",
               busy, done, dout_valid);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_w [4];
    exp_w[0] = 130; exp_w[1] = 131; exp_w[2] = 100; exp_w[3] = 101;
    dout_ready = 1'b1;
    issue_start(5'd30, 6'd4);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_w[k]) begin
        errors++;
        $display("FAIL wrap_word%0d: valid=%b dout=%0d, want 1 %0d",
                 k, dout_valid, dout, exp_w[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int waited;
    int dones;
    dout_ready = 1'b0;
    issue_start(5'd5, 6'd8);
    waited = 0;
    while (dout_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_valid: no valid within 10 cycles, want valid=1");
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== DW'(105)) begin
        errors++;
        $display("FAIL bp_frozen%0d: valid=%b dout=%0d, want 1 105", k, dout_valid, dout);
      end
      @(negedge clk);
    end
    checks++;
    if (rd_addr !== 5'd8) begin
      errors++;
      $display("FAIL bp_reads_issued: rd_addr=%0d want 8 (four reads)", rd_addr);
    end
    dout_ready = 1'b1;
    n = 0; dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) dones++;
      if (dout_valid === 1'b1) begin
        checks++;
        if (dout !== DW'(105 + n) || done !== (n == 7)) begin
          errors++;
          $display("FAIL bp_word%0d: dout=%0d done=%b, want %0d %b",
                   n, dout, done, 105 + n, n == 7);
        end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 8 || dones != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_totals: words=%0d dones=%0d busy=%b, want 8 1 0", n, dones, busy);
    end
  endtask

  task automatic test_zero_length();
    int seen_valid;
    dout_ready = 1'b1;
    issue_start(5'd7, 6'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b, want 1 0", done, busy);
    end
    seen_valid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dout_valid === 1'b1 || busy === 1'b1 || done === 1'b1) seen_valid++;
    end
    checks++;
    if (seen_valid != 0) begin
      errors++;
      $display("FAIL zero_quiet: %0d active cycles, want 0", seen_valid);
    end
  endtask

  task automatic test_clamp();
    int n;
    int dones;
    dout_ready = 1'b1;
    issue_start(5'd10, 6'd40);
    n = 0; dones = 0;
    for (int c = 0; c < 60; c++) begin
      start = (c == 10);
      base_addr = '0;
      length = 6'd3;
      if (done === 1'b1) dones++;
      if (dout_valid === 1'b1) begin
        checks++;
        if (dout !== DW'(100 + ((10 + n) % 32)) || done !== (n == 31)) begin
          errors++;
          $display("FAIL clamp_word%0d: dout=%0d done=%b, want %0d %b",
                   n, dout, done, 100 + ((10 + n) % 32), n == 31);
        end
        n++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n != 32 || dones != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clamp_totals: words=%0d dones=%0d busy=%b, want 32 1 0", n, dones, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    int active;
    dout_ready = 1'b1;
    issue_start(5'd3, 6'd6);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dout !== DW'(103)) begin
      errors++;
      $display("FAIL rstmid_word0: dout=%0d want 103", dout);
    end
    @(negedge clk);
    checks++;
    if (dout !== DW'(104)) begin
      errors++;
      $display("FAIL rstmid_word1: dout=%0d want 104", dout);
    end
    rst = 1'b1;
    start = 1'b1; base_addr = 5'd20; length = 6'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({dout_valid, busy, done} !== 3'b000 || rd_addr !== '0 || dout !== '0) begin
      errors++;
      $display("FAIL rstmid_state: valid=%b busy=%b done=%b rd_addr=%0d dout=%0d, want 0s",
               dout_valid, busy, done, rd_addr, dout);
    end
    active = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dout_valid === 1'b1 || done === 1'b1 || busy === 1'b1) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: %0d active cycles, want 0", active);
    end
    test_basic();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = DW'(i + 100);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_clamp();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
